// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if -- EX-stage branch resolution bundle.
//   EX inputs    : i_Valid, i_Is_Branch, i_Br_Taken, i_Pred_Taken, i_PPC_Eq,
//                  i_Br_PC, i_ALU_rslt
//   PC control   : o_NPC_Ctrl, o_PC_Load, o_Flush, o_Stall
//   Predictor upd: o_Upd_Valid / i_Upd_Ready handshake,
//                  payload o_Upd_PC, o_Upd_Target, o_Upd_Taken
// slave modport is the controller side; master is the pipeline/predictor side.
interface branch_resolve_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             i_Valid;
  logic             i_Is_Branch;
  logic             i_Br_Taken;
  logic             i_Pred_Taken;
  logic             i_PPC_Eq;
  logic [WIDTH-1:0] i_Br_PC;
  logic [WIDTH-1:0] i_ALU_rslt;
  logic             i_Upd_Ready;
  logic             o_NPC_Ctrl;
  logic             o_PC_Load;
  logic             o_Flush;
  logic             o_Stall;
  logic             o_Upd_Valid;
  logic [WIDTH-1:0] o_Upd_PC;
  logic [WIDTH-1:0] o_Upd_Target;
  logic             o_Upd_Taken;

  modport slave (
    input  i_Valid, i_Is_Branch, i_Br_Taken, i_Pred_Taken, i_PPC_Eq,
           i_Br_PC, i_ALU_rslt, i_Upd_Ready,
    output o_NPC_Ctrl, o_PC_Load, o_Flush, o_Stall,
           o_Upd_Valid, o_Upd_PC, o_Upd_Target, o_Upd_Taken
  );

  modport master (
    output i_Valid, i_Is_Branch, i_Br_Taken, i_Pred_Taken, i_PPC_Eq,
           i_Br_PC, i_ALU_rslt, i_Upd_Ready,
    input  o_NPC_Ctrl, o_PC_Load, o_Flush, o_Stall,
           o_Upd_Valid, o_Upd_PC, o_Upd_Target, o_Upd_Taken
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl -- resolves EX-stage branches, drives mispredict
// recovery (PC reload + pipeline flush) and hands resolved branches to the
// predictor through a one-entry update buffer.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   br           : branch_resolve_ctrl_if.slave (EX inputs, PC control,
//                  predictor-update handshake)
//   o_Br_Cnt, o_Mispred_Cnt : saturating perf counters, present only when
//                  BR_PERF_CNT_EN is defined
// Parameters: WIDTH (PC width), FLUSH_CYCLES (1..3, recovery length).
module branch_resolve_ctrl #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  branch_resolve_ctrl_if.slave  br
`ifdef BR_PERF_CNT_EN
  ,
  output logic [15:0]           o_Br_Cnt,
  output logic [15:0]           o_Mispred_Cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;   // 2 bits covers FLUSH_CYCLES 1..3

  logic             stall;
  logic             resolve;
  logic             mispred;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic [WIDTH-1:0] upd_target;
  logic             upd_taken;

  // Stall only when the buffer is full and blocked; in RECOVER EX is masked,
  // so there is nothing to hold.
  assign stall   = upd_valid & ~br.i_Upd_Ready & br.i_Valid & br.i_Is_Branch
                   & (state == IDLE);
  assign resolve = br.i_Valid & br.i_Is_Branch & ~stall & (state == IDLE);
  assign mispred = (br.i_Br_Taken != br.i_Pred_Taken)
                   | (br.i_Br_Taken & ~br.i_PPC_Eq);

  assign br.o_NPC_Ctrl   = ~br.i_Br_Taken;
  assign br.o_Stall      = stall;
  assign br.o_Upd_Valid  = upd_valid;
  assign br.o_Upd_PC     = upd_pc;
  assign br.o_Upd_Target = upd_target;
  assign br.o_Upd_Taken  = upd_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    br.o_Flush    = 1'b0;
    br.o_PC_Load  = 1'b0;
    case (state)
      IDLE: begin
        if (resolve && mispred) begin
          state_nxt     = RECOVER;
          flush_cnt_nxt = 2'(FLUSH_CYCLES);
        end
      end
      RECOVER: begin
        br.o_Flush    = 1'b1;
        // Counter still holds its load value only in the first RECOVER cycle.
        br.o_PC_Load  = (flush_cnt == 2'(FLUSH_CYCLES));
        flush_cnt_nxt = flush_cnt - 2'd1;
        if (flush_cnt == 2'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-entry update buffer; capture wins over release so a simultaneous
  // release+capture keeps valid high with the new payload.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_target <= '0;
      upd_taken  <= 1'b0;
    end else if (resolve) begin
      upd_valid  <= 1'b1;
      upd_pc     <= br.i_Br_PC;
      upd_target <= br.i_ALU_rslt;
      upd_taken  <= br.i_Br_Taken;
    end else if (upd_valid && br.i_Upd_Ready) begin
      upd_valid  <= 1'b0;
    end
  end

`ifdef BR_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_Br_Cnt      <= 16'd0;
      o_Mispred_Cnt <= 16'd0;
    end else if (resolve) begin
      if (o_Br_Cnt != 16'hFFFF) o_Br_Cnt <= o_Br_Cnt + 16'd1;
      if (mispred && o_Mispred_Cnt != 16'hFFFF)
        o_Mispred_Cnt <= o_Mispred_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.WIDTH(32)) bif ();

`ifdef BR_PERF_CNT_EN
  logic [15:0] br_cnt, mis_cnt;
`endif

  branch_resolve_ctrl #(.WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .br    (bif)
`ifdef BR_PERF_CNT_EN
    ,
    .o_Br_Cnt      (br_cnt),
    .o_Mispred_Cnt (mis_cnt)
`endif
  );

  // Inputs change at negedge; checks run 1 time unit later, far from posedge.
  task automatic drive(input logic v, input logic taken, input logic pred,
                       input logic eq, input logic [31:0] pc,
                       input logic [31:0] alu);
    bif.i_Valid      = v;
    bif.i_Is_Branch  = v;
    bif.i_Br_Taken   = taken;
    bif.i_Pred_Taken = pred;
    bif.i_PPC_Eq     = eq;
    bif.i_Br_PC      = pc;
    bif.i_ALU_rslt   = alu;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    bif.i_Upd_Ready = 1'b1;
    rst = 1'b1;
    next_cycle();
    n_total++; if (bif.o_Upd_Valid !== 1'b0) $display("FAIL rst_upd_valid got %b want 0", bif.o_Upd_Valid); else n_pass++;
    n_total++; if (bif.o_Flush !== 1'b0) $display("FAIL rst_flush got %b want 0", bif.o_Flush); else n_pass++;
    n_total++; if (bif.o_PC_Load !== 1'b0) $display("FAIL rst_pc_load got %b want 0", bif.o_PC_Load); else n_pass++;
    n_total++; if (bif.o_Upd_PC !== 32'h0 || bif.o_Upd_Target !== 32'h0 || bif.o_Upd_Taken !== 1'b0)
      $display("FAIL rst_payload got %h/%h/%b want 0/0/0", bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Upd_Taken); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_correct_taken();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h140);
    #1;
    n_total++; if (bif.o_NPC_Ctrl !== 1'b0) $display("FAIL ct_npc got %b want 0", bif.o_NPC_Ctrl); else n_pass++;
    n_total++; if (bif.o_Stall !== 1'b0) $display("FAIL ct_stall got %b want 0", bif.o_Stall); else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    n_total++; if (bif.o_Upd_Valid !== 1'b1) $display("FAIL ct_upd_valid got %b want 1", bif.o_Upd_Valid); else n_pass++;
    n_total++; if (bif.o_Upd_PC !== 32'h100 || bif.o_Upd_Target !== 32'h140 || bif.o_Upd_Taken !== 1'b1)
      $display("FAIL ct_payload got %h/%h/%b want 100/140/1", bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Upd_Taken); else n_pass++;
    n_total++; if (bif.o_Flush !== 1'b0 || bif.o_PC_Load !== 1'b0)
      $display("FAIL ct_no_flush got flush=%b load=%b want 0/0", bif.o_Flush, bif.o_PC_Load); else n_pass++;
    next_cycle();
    n_total++; if (bif.o_Upd_Valid !== 1'b0) $display("FAIL ct_release got %b want 0", bif.o_Upd_Valid); else n_pass++;
  endtask

  // Shared recovery-sequence check for both mispredict flavours.
  task automatic test_mispredict(input logic taken, input logic pred,
                                 input logic eq, input logic [31:0] pc,
                                 input logic npc_exp);
`ifdef BR_PERF_CNT_EN
    logic [15:0] mis_before;
    mis_before = mis_cnt;
`endif
    drive(1'b1, taken, pred, eq, pc, pc + 32'h40);
    #1;
    n_total++; if (bif.o_NPC_Ctrl !== npc_exp) $display("FAIL mp_npc pc=%h got %b want %b", pc, bif.o_NPC_Ctrl, npc_exp); else n_pass++;
    n_total++; if (bif.o_PC_Load !== 1'b0) $display("FAIL mp_load_early got %b want 0", bif.o_PC_Load); else n_pass++;
    next_cycle();
    // A branch in EX during RECOVER must be ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h999, 32'h9F0);
    n_total++; if (bif.o_PC_Load !== 1'b1 || bif.o_Flush !== 1'b1)
      $display("FAIL mp_c1 got load=%b flush=%b want 1/1", bif.o_PC_Load, bif.o_Flush); else n_pass++;
    n_total++; if (bif.o_Upd_Valid !== 1'b1 || bif.o_Upd_PC !== pc || bif.o_Upd_Taken !== taken)
      $display("FAIL mp_upd got %b/%h/%b want 1/%h/%b", bif.o_Upd_Valid, bif.o_Upd_PC, bif.o_Upd_Taken, pc, taken); else n_pass++;
    n_total++; if (bif.o_Stall !== 1'b0) $display("FAIL mp_stall_rec got %b want 0", bif.o_Stall); else n_pass++;
    next_cycle();
    n_total++; if (bif.o_PC_Load !== 1'b0 || bif.o_Flush !== 1'b1)
      $display("FAIL mp_c2 got load=%b flush=%b want 0/1", bif.o_PC_Load, bif.o_Flush); else n_pass++;
    n_total++; if (bif.o_Upd_Valid !== 1'b0) $display("FAIL mp_masked_capture got %b want 0", bif.o_Upd_Valid); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    next_cycle();
    n_total++; if (bif.o_Flush !== 1'b0 || bif.o_PC_Load !== 1'b0)
      $display("FAIL mp_idle got load=%b flush=%b want 0/0", bif.o_PC_Load, bif.o_Flush); else n_pass++;
`ifdef BR_PERF_CNT_EN
    n_total++; if (mis_cnt !== mis_before + 16'd1) $display("FAIL mp_cnt got %0d want %0d", mis_cnt, mis_before + 16'd1); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    bif.i_Upd_Ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h340);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 32'h440);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bif.o_Stall !== 1'b1) $display("FAIL bp_stall c%0d got %b want 1", i, bif.o_Stall); else n_pass++;
      n_total++; if (bif.o_Upd_Valid !== 1'b1 || bif.o_Upd_PC !== 32'h300 || bif.o_Upd_Target !== 32'h340 || bif.o_Upd_Taken !== 1'b1)
        $display("FAIL bp_hold c%0d got %b/%h/%h/%b want 1/300/340/1", i, bif.o_Upd_Valid, bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Upd_Taken); else n_pass++;
      next_cycle();
    end
    bif.i_Upd_Ready = 1'b1;
    #1;
    n_total++; if (bif.o_Stall !== 1'b0) $display("FAIL bp_unstall got %b want 0", bif.o_Stall); else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    n_total++; if (bif.o_Upd_Valid !== 1'b1 || bif.o_Upd_PC !== 32'h400 || bif.o_Upd_Target !== 32'h440 || bif.o_Upd_Taken !== 1'b0)
      $display("FAIL bp_second got %b/%h/%h/%b want 1/400/440/0", bif.o_Upd_Valid, bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Upd_Taken); else n_pass++;
    next_cycle();
    n_total++; if (bif.o_Upd_Valid !== 1'b0) $display("FAIL bp_drain got %b want 0", bif.o_Upd_Valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h640);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h780);
    n_total++; if (bif.o_Upd_PC !== 32'h600 || bif.o_Upd_Taken !== 1'b0)
      $display("FAIL b2b_first got %h/%b want 600/0", bif.o_Upd_PC, bif.o_Upd_Taken); else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    n_total++; if (bif.o_Upd_Valid !== 1'b1 || bif.o_Upd_PC !== 32'h700 || bif.o_Upd_Target !== 32'h780 || bif.o_Upd_Taken !== 1'b1)
      $display("FAIL b2b_second got %b/%h/%h/%b want 1/700/780/1", bif.o_Upd_Valid, bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Upd_Taken); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_recover();
    bif.i_Upd_Ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h800, 32'h840);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    next_cycle();
    n_total++; if (bif.o_Flush !== 1'b1 || bif.o_Upd_Valid !== 1'b1)
      $display("FAIL rr_pre got flush=%b upd=%b want 1/1", bif.o_Flush, bif.o_Upd_Valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bif.o_Flush !== 1'b0 || bif.o_PC_Load !== 1'b0)
      $display("FAIL rr_flush got flush=%b load=%b want 0/0", bif.o_Flush, bif.o_PC_Load); else n_pass++;
    n_total++; if (bif.o_Upd_Valid !== 1'b0 || bif.o_Upd_PC !== 32'h0)
      $display("FAIL rr_upd got %b/%h want 0/0", bif.o_Upd_Valid, bif.o_Upd_PC); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bif.i_Upd_Ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h540);
    #1;
    n_total++; if (bif.o_NPC_Ctrl !== 1'b1 || bif.o_Stall !== 1'b0)
      $display("FAIL rr_post_in got npc=%b stall=%b want 1/0", bif.o_NPC_Ctrl, bif.o_Stall); else n_pass++;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    n_total++; if (bif.o_Upd_Valid !== 1'b1 || bif.o_Upd_PC !== 32'h500 || bif.o_Upd_Target !== 32'h540 || bif.o_Flush !== 1'b0)
      $display("FAIL rr_post got %b/%h/%h flush=%b want 1/500/540/0", bif.o_Upd_Valid, bif.o_Upd_PC, bif.o_Upd_Target, bif.o_Flush); else n_pass++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_mispredict(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);  // predicted taken, resolved not-taken
    test_mispredict(1'b1, 1'b1, 1'b0, 32'h240, 1'b0);  // taken, wrong target
    test_backpressure();
    test_back_to_back();
    test_reset_mid_recover();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the PC and target datapath width.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..3, sets the pipeline flush length after a mispredict.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_Valid  in  1  EX stage holds a valid instruction this cycle.
REQ-006 i_Is_Branch  in  1  EX instruction is a branch or jump.
REQ-007 i_Br_Taken  in  1  resolved branch condition (1 = taken).
REQ-008 i_Pred_Taken  in  1  fetch-time prediction carried in ID/EX.
REQ-009 i_PPC_Eq  in  1  predicted PC equals the ALU target, from the PC evaluation stage.
REQ-010 i_Br_PC  in  WIDTH  branch instruction address.
REQ-011 i_ALU_rslt  in  WIDTH  computed branch target.
REQ-012 o_NPC_Ctrl  out  1  new-PC select to PC evaluation: 1 = fall-through PC, 0 = ALU target.
REQ-013 o_PC_Load  out  1  one-cycle pulse that loads the new PC into fetch.
REQ-014 o_Flush  out  1  flush the IF/ID and ID/EX registers.
REQ-015 o_Stall  out  1  hold the EX stage.
REQ-016 o_Upd_Valid / i_Upd_Ready  out/in  1/1  predictor-update handshake.
REQ-017 o_Upd_PC, o_Upd_Target  out  WIDTH  update payload.
REQ-018 o_Upd_Taken  out  1  update payload, resolved direction.

Function
REQ-019 A branch is resolved in a cycle when i_Valid & i_Is_Branch & !o_Stall and the FSM is in IDLE.
REQ-020 o_NPC_Ctrl = !i_Br_Taken, combinational, regardless of FSM state.
REQ-021 A resolved branch is mispredicted when (i_Br_Taken != i_Pred_Taken) or (i_Br_Taken & !i_PPC_Eq).
REQ-022 The FSM has two states, IDLE and RECOVER.
REQ-023 A mispredict resolved in IDLE moves the FSM to RECOVER at the next edge and loads a flush counter with FLUSH_CYCLES.
REQ-024 In RECOVER, o_Flush = 1 every cycle; o_PC_Load = 1 only in the first RECOVER cycle; the counter decrements each cycle; the FSM returns to IDLE after FLUSH_CYCLES cycles.
REQ-025 Mispredict-to-o_PC_Load latency is exactly 1 cycle.
REQ-026 In RECOVER, EX inputs are ignored: no resolution, no update capture.
REQ-027 Every resolved branch (taken, not-taken, mispredicted or not) captures {i_Br_PC, i_ALU_rslt, i_Br_Taken} into a one-entry update buffer at the next edge, setting o_Upd_Valid.
REQ-028 The payload stays stable while o_Upd_Valid & !i_Upd_Ready.
REQ-029 An entry is released on o_Upd_Valid & i_Upd_Ready.
REQ-030 If release and a new capture coincide, the new entry is loaded and o_Upd_Valid stays 1.
REQ-031 o_Stall = o_Upd_Valid & !i_Upd_Ready & i_Valid & i_Is_Branch & (state == IDLE), combinational.
REQ-032 A stalled branch is not resolved until the stall clears.
REQ-033 Back-to-back mispredicts are impossible by construction, because RECOVER masks EX.

Reset
REQ-034 i_rst asserted at any time forces, immediately and asynchronously, FSM = IDLE, flush counter = 0, o_PC_Load = 0, o_Flush = 0, o_Upd_Valid = 0, o_Upd_PC = 0, o_Upd_Target = 0, o_Upd_Taken = 0.
REQ-035 Reset mid-RECOVER aborts the flush, and any pending update is discarded.
REQ-036 The first resolution after reset is possible in the first cycle i_rst is low.

Configuration
REQ-037 Macro BR_PERF_CNT_EN, when defined, adds outputs o_Br_Cnt[15:0] and o_Mispred_Cnt[15:0], both reset to 0.
REQ-038 With BR_PERF_CNT_EN defined, the counters increment once per resolved branch and per mispredict respectively, and saturate at 16'hFFFF.
REQ-039 With BR_PERF_CNT_EN undefined, these ports and counters do not exist and all other behaviour is identical.

Verification
REQ-040 Correctly predicted taken branch (Pred_Taken=1, Br_Taken=1, PPC_Eq=1, Br_PC=0x100, ALU=0x140) -> no flush, o_NPC_Ctrl=0, next cycle o_Upd_Valid=1 with 0x100/0x140/1.
REQ-041 Mispredicted not-taken (Pred_Taken=1, Br_Taken=0) with FLUSH_CYCLES=2 -> o_PC_Load=1 for 1 cycle, o_Flush=1 for 2 cycles starting 1 cycle later, o_NPC_Ctrl=1, then IDLE.
REQ-042 Taken with wrong target (PPC_Eq=0) -> mispredict path as in REQ-041; with BR_PERF_CNT_EN, o_Mispred_Cnt increments by 1.
REQ-043 i_Upd_Ready held 0 for 3 cycles, second branch presented -> o_Stall=1 for 3 cycles, payload stable, second capture on the cycle Ready returns to 1.
REQ-044 i_rst pulsed in the second RECOVER cycle -> o_Flush, o_Upd_Valid and state clear at once; a branch presented after reset resolves normally.
